// File: rtl/cpu_pkg.sv
// Shared CPU-side definitions for the memory responder: mode encodings,
// bus widths and the responder FSM state type.
package cpu_pkg;

    localparam int DATA_W = 8;
    localparam int ADDR_W = 16;

    localparam logic [1:0] CPU_IDLE  = 2'b00;
    localparam logic [1:0] CPU_IN    = 2'b01;
    localparam logic [1:0] CPU_CHECK = 2'b10;
    localparam logic [1:0] CPU_RUN   = 2'b11;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_FULL,
        S_CHK,
        S_CHKDONE,
        S_RUN
    } state_t;

    // State entered when the CPU switches into the given mode.
    function automatic state_t state_for(input logic [1:0] cs);
        state_t st;
        case (cs)
            CPU_IN:    st = S_LOAD;
            CPU_CHECK: st = S_CHK;
            CPU_RUN:   st = S_RUN;
            default:   st = S_IDLE;
        endcase
        return st;
    endfunction

endpackage

// File: rtl/mem_responder_if.sv
// CPU bus, program-load stream, readback stream and status signals of the
// memory responder; slave is the responder side, master the CPU/host side.
interface mem_responder_if #(parameter int AW = 8);
    import cpu_pkg::*;

    logic [1:0]        cpu_state;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] bus_in;
    logic [DATA_W-1:0] bus_out;
    logic              mem_read;
    logic              mem2bus;
    logic              mem_write;
    logic              bus2mem;
    logic [DATA_W-1:0] load_data;
    logic              load_valid;
    logic              load_ready;
    logic [DATA_W-1:0] chk_data;
    logic [AW-1:0]     chk_addr;
    logic              chk_valid;
    logic              chk_ready;
    logic [AW:0]       ld_count;
    logic              load_full;
    logic              addr_err;
    logic              proto_err;

    modport slave (
        input  cpu_state, addr, bus_in, mem_read, mem2bus, mem_write, bus2mem,
               load_data, load_valid, chk_ready,
        output bus_out, load_ready, chk_data, chk_addr, chk_valid,
               ld_count, load_full, addr_err, proto_err
    );

    modport master (
        output cpu_state, addr, bus_in, mem_read, mem2bus, mem_write, bus2mem,
               load_data, load_valid, chk_ready,
        input  bus_out, load_ready, chk_data, chk_addr, chk_valid,
               ld_count, load_full, addr_err, proto_err
    );

endinterface

// File: rtl/cpu_ram.sv
// Byte-wide storage: one asynchronous read port, one synchronous write port.
// Contents are deliberately not reset.
module cpu_ram
    import cpu_pkg::*;
#(
    parameter int AW = 8
) (
    input  logic              clk,
    input  logic              we,
    input  logic [AW-1:0]     waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [AW-1:0]     raddr,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem [2**AW];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/mem_responder.sv
// Memory responder: loads a program byte stream, streams it back for
// checking, then serves CPU reads/writes in RUN mode with error flags.
module mem_responder
    import cpu_pkg::*;
#(
    parameter int AW = 8
) (
    input  logic          clk,
    input  logic          reset,
    mem_responder_if.slave bus
);

    state_t            state, state_nxt;
    logic [1:0]        prev_state;
    logic [AW-1:0]     ld_ptr;
    logic [AW:0]       ld_count, ld_count_inc;
    logic [AW:0]       chk_ptr;
    logic [DATA_W-1:0] chk_data;
    logic [AW-1:0]     chk_addr;
    logic              chk_valid;
    logic              addr_err, proto_err;

    logic              mode_change;
    logic              load_fire;
    logic              chk_fetch, chk_more;
    logic              in_range;
    logic              run_rd, run_wr;
    logic              ram_we;
    logic [AW-1:0]     ram_waddr, ram_raddr;
    logic [DATA_W-1:0] ram_wdata, ram_rdata;

    assign mode_change  = (bus.cpu_state != prev_state);
    assign ld_count_inc = ld_count + (AW+1)'(1);
    assign load_fire    = (state == S_LOAD) && bus.load_valid && !mode_change;
    // chk_ptr points at the next byte to fetch, so it runs one ahead of chk_addr.
    assign chk_fetch    = (state == S_CHK) && (!chk_valid || bus.chk_ready);
    assign chk_more     = (chk_ptr < ld_count);
    assign in_range     = ((bus.addr >> AW) == '0);
    assign run_rd       = (state == S_RUN) && bus.mem_read;
    assign run_wr       = (state == S_RUN) && bus.mem_write;

    assign ram_we    = load_fire || (run_wr && bus.bus2mem && in_range);
    assign ram_waddr = (state == S_LOAD) ? ld_ptr : bus.addr[AW-1:0];
    assign ram_wdata = (state == S_LOAD) ? bus.load_data : bus.bus_in;
    assign ram_raddr = (state == S_CHK) ? chk_ptr[AW-1:0] : bus.addr[AW-1:0];

    cpu_ram #(.AW(AW)) u_ram (
        .clk   (clk),
        .we    (ram_we),
        .waddr (ram_waddr),
        .wdata (ram_wdata),
        .raddr (ram_raddr),
        .rdata (ram_rdata)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= S_IDLE;
            prev_state <= CPU_IDLE;
        end else begin
            state      <= state_nxt;
            prev_state <= bus.cpu_state;
        end
    end

    always_comb begin
        state_nxt = state;
        if (mode_change) begin
            state_nxt = state_for(bus.cpu_state);
        end else begin
            case (state)
                S_LOAD:  if (load_fire && ld_count_inc[AW]) state_nxt = S_FULL;
                S_CHK:   if (chk_fetch && !chk_more) state_nxt = S_CHKDONE;
                default: state_nxt = state;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ld_ptr    <= '0;
            ld_count  <= '0;
            chk_ptr   <= '0;
            chk_data  <= '0;
            chk_addr  <= '0;
            chk_valid <= 1'b0;
            addr_err  <= 1'b0;
            proto_err <= 1'b0;
        end else begin
            if (run_rd || run_wr) begin
                if (!in_range)        addr_err  <= 1'b1;
                if (run_rd && run_wr) proto_err <= 1'b1;
            end
            // Mode entry comes last so its flag clear wins over a same-edge set.
            if (mode_change) begin
                chk_valid <= 1'b0;
                if (bus.cpu_state == CPU_IN) begin
                    ld_ptr    <= '0;
                    ld_count  <= '0;
                    addr_err  <= 1'b0;
                    proto_err <= 1'b0;
                end
                if (bus.cpu_state == CPU_CHECK) begin
                    chk_ptr <= '0;
                end
            end else begin
                if (load_fire) begin
                    ld_ptr   <= ld_ptr + AW'(1);
                    ld_count <= ld_count_inc;
                end
                if (chk_fetch) begin
                    if (chk_more) begin
                        chk_valid <= 1'b1;
                        chk_data  <= ram_rdata;
                        chk_addr  <= chk_ptr[AW-1:0];
                        chk_ptr   <= chk_ptr + (AW+1)'(1);
                    end else begin
                        chk_valid <= 1'b0;
                    end
                end
            end
        end
    end

    assign bus.bus_out    = (run_rd && bus.mem2bus && in_range && !bus.mem_write) ? ram_rdata : '0;
    assign bus.load_ready = (state == S_LOAD) && !mode_change;
    assign bus.load_full  = ld_count[AW];
    assign bus.ld_count   = ld_count;
    assign bus.chk_data   = chk_data;
    assign bus.chk_addr   = chk_addr;
    assign bus.chk_valid  = chk_valid;
    assign bus.addr_err   = addr_err;
    assign bus.proto_err  = proto_err;

endmodule

// File: tb/tb_mem_responder.sv
// Randomized self-checking bench for mem_responder against a byte-array
// reference model; a second AW=2 instance covers the full-memory case.
module tb_mem_responder;
    import cpu_pkg::*;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    mem_responder_if #(.AW(8)) ifc8 ();
    mem_responder_if #(.AW(2)) ifc2 ();

    mem_responder #(.AW(8)) dut8 (.clk(clk), .reset(reset), .bus(ifc8));
    mem_responder #(.AW(2)) dut2 (.clk(clk), .reset(reset), .bus(ifc2));

    int total = 0;
    int bad   = 0;

    logic [7:0] ref_mem [256];
    bit         known   [256];
    int         ref_cnt;
    bit         ref_aerr, ref_perr;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic clear_bus8();
        ifc8.mem_read = 0; ifc8.mem2bus = 0; ifc8.mem_write = 0; ifc8.bus2mem = 0;
        ifc8.addr = '0; ifc8.bus_in = '0; ifc8.load_valid = 0; ifc8.load_data = '0;
        ifc8.chk_ready = 0;
    endtask

    // Streams expected bytes 0..n-1; called right after the CHECK entry edge.
    task automatic check_stream(input int n, input bit rnd);
        int idx = 0;
        int tmo = 0;
        bit tog = 0;
        check_eq("chk_entry_valid", ifc8.chk_valid, 0);
        cyc();
        check_eq("chk_first_valid", ifc8.chk_valid, (n > 0));
        while (idx < n && tmo < 400) begin
            ifc8.chk_ready = rnd ? 1'($urandom_range(0, 1)) : tog;
            tog = ~tog;
            #1;
            if (ifc8.chk_valid) begin
                check_eq("chk_addr", ifc8.chk_addr, idx);
                check_eq("chk_data", ifc8.chk_data, ref_mem[idx]);
                if (ifc8.chk_ready) idx++;
            end
            cyc();
            tmo++;
        end
        check_eq("chk_no_timeout", (tmo < 400), 1);
        ifc8.chk_ready = 0;
        #1;
        check_eq("chk_done_valid", ifc8.chk_valid, 0);
        check_eq("chk_done_state", 32'(dut8.state), 32'(S_CHKDONE));
    endtask

    task automatic run_op(input logic rd, input logic wr, input logic m2b, input logic b2m,
                          input logic [15:0] a, input logic [7:0] d);
        bit inr;
        bit rd_ok;
        inr   = (a < 16'd256);
        rd_ok = rd && m2b && inr && !wr;
        ifc8.mem_read = rd; ifc8.mem_write = wr; ifc8.mem2bus = m2b; ifc8.bus2mem = b2m;
        ifc8.addr = a; ifc8.bus_in = d;
        #1;
        if (rd_ok && known[a[7:0]]) check_eq("run_rd_data", ifc8.bus_out, ref_mem[a[7:0]]);
        else if (!rd_ok)            check_eq("run_bus_zero", ifc8.bus_out, 0);
        cyc();
        if (wr && b2m && inr) begin
            ref_mem[a[7:0]] = d;
            known[a[7:0]]   = 1;
        end
        if ((rd || wr) && !inr) ref_aerr = 1;
        if (rd && wr)           ref_perr = 1;
        check_eq("run_addr_err", ifc8.addr_err, ref_aerr);
        check_eq("run_proto_err", ifc8.proto_err, ref_perr);
    endtask

    task automatic random_run(input int n);
        logic [15:0] a;
        int kind;
        for (int i = 0; i < n; i++) begin
            a = ($urandom_range(0, 3) != 0) ? 16'($urandom_range(0, 255))
                                            : 16'($urandom_range(256, 65535));
            kind = $urandom_range(0, 9);
            run_op(kind < 5, kind >= 4, $urandom_range(0, 5) != 0, $urandom_range(0, 5) != 0,
                   a, 8'($urandom));
        end
        clear_bus8();
    endtask

    task automatic load_stream(input int n);
        int k = 0;
        int tmo = 0;
        bit v;
        logic [7:0] d;
        while (k < n && tmo < 400) begin
            v = ($urandom_range(0, 3) != 0);
            d = 8'($urandom);
            ifc8.load_valid = v;
            ifc8.load_data  = d;
            #1;
            check_eq("ld_ready", ifc8.load_ready, 1);
            cyc();
            if (v) begin
                ref_mem[k] = d;
                known[k]   = 1;
                k++;
            end
            tmo++;
        end
        ifc8.load_valid = 0;
        ref_cnt = k;
        check_eq("ld_count", ifc8.ld_count, ref_cnt);
    endtask

    logic [7:0] seq3 [3];

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        seq3 = '{8'h11, 8'h22, 8'h33};
        for (int i = 0; i < 256; i++) known[i] = 0;
        ref_cnt = 0; ref_aerr = 0; ref_perr = 0;
        reset = 0;
        ifc8.cpu_state = CPU_IDLE;
        clear_bus8();
        ifc2.cpu_state = CPU_IDLE; ifc2.addr = '0; ifc2.bus_in = '0;
        ifc2.mem_read = 0; ifc2.mem2bus = 0; ifc2.mem_write = 0; ifc2.bus2mem = 0;
        ifc2.load_data = '0; ifc2.load_valid = 0; ifc2.chk_ready = 0;

        #22;
        check_eq("rst_bus_out", ifc8.bus_out, 0);
        check_eq("rst_load_ready", ifc8.load_ready, 0);
        check_eq("rst_chk_valid", ifc8.chk_valid, 0);
        check_eq("rst_ld_count", ifc8.ld_count, 0);
        check_eq("rst_flags", {ifc8.load_full, ifc8.addr_err, ifc8.proto_err}, 0);
        check_eq("rst_chk_regs", {ifc8.chk_data, ifc8.chk_addr}, 0);
        check_eq("rst_ld_count2", ifc2.ld_count, 0);
        @(negedge clk);
        reset = 1;
        cyc();

        // Small instance: only four bytes fit, the fifth must be refused.
        ifc2.cpu_state = CPU_IN;
        cyc();
        for (int i = 0; i < 5; i++) begin
            ifc2.load_valid = 1;
            ifc2.load_data  = 8'hA0 + 8'(i);
            #1;
            check_eq("full_ready", ifc2.load_ready, (i < 4));
            cyc();
        end
        ifc2.load_valid = 0;
        check_eq("full_count", ifc2.ld_count, 4);
        check_eq("full_flag", ifc2.load_full, 1);
        check_eq("full_ready_after", ifc2.load_ready, 0);
        ifc2.cpu_state = CPU_RUN;
        cyc();
        ifc2.mem_read = 1; ifc2.mem2bus = 1;
        for (int i = 0; i < 4; i++) begin
            ifc2.addr = 16'(i);
            #1;
            check_eq("full_mem", ifc2.bus_out, 8'hA0 + 8'(i));
        end
        ifc2.mem_read = 0; ifc2.mem2bus = 0;

        // Fixed three-byte load, then readback with alternating ready.
        ifc8.cpu_state = CPU_IN;
        cyc();
        check_eq("in_ready", ifc8.load_ready, 1);
        check_eq("in_count0", ifc8.ld_count, 0);
        for (int i = 0; i < 3; i++) begin
            ifc8.load_valid = 1;
            ifc8.load_data  = seq3[i];
            cyc();
            ref_mem[i] = seq3[i];
            known[i]   = 1;
        end
        ifc8.load_valid = 0;
        ref_cnt = 3;
        check_eq("in_count3", ifc8.ld_count, 3);
        check_eq("in_not_full", ifc8.load_full, 0);

        ifc8.cpu_state = CPU_CHECK;
        cyc();
        check_stream(ref_cnt, 0);

        ifc8.cpu_state = CPU_RUN;
        cyc();
        check_eq("run_ld_count_kept", ifc8.ld_count, 3);
        run_op(0, 1, 0, 1, 16'h0010, 8'h5A);
        run_op(1, 0, 1, 0, 16'h0010, 8'h00);
        run_op(1, 0, 1, 0, 16'h0100, 8'h00);
        check_eq("addr_err_set", ifc8.addr_err, 1);
        run_op(1, 1, 1, 1, 16'h0003, 8'hC3);
        check_eq("proto_err_set", ifc8.proto_err, 1);
        run_op(1, 0, 1, 0, 16'h0003, 8'h00);
        check_eq("after_proto_data", ref_mem[3], 8'hC3);
        random_run(120);

        // Random load / check / run round.
        ifc8.cpu_state = CPU_IN;
        cyc();
        ref_aerr = 0; ref_perr = 0;
        check_eq("flags_clear_on_in", {ifc8.addr_err, ifc8.proto_err}, 0);
        load_stream($urandom_range(1, 24));
        ifc8.cpu_state = CPU_CHECK;
        cyc();
        check_stream(ref_cnt, 1);
        ifc8.cpu_state = CPU_RUN;
        cyc();
        random_run(150);

        // Empty check: reload nothing, CHECK must finish without presenting data.
        ifc8.cpu_state = CPU_IN;
        cyc();
        ref_aerr = 0; ref_perr = 0; ref_cnt = 0;
        ifc8.cpu_state = CPU_CHECK;
        cyc();
        check_stream(0, 1);

        // Reset in the middle of a readback.
        ifc8.cpu_state = CPU_IN;
        cyc();
        load_stream(4);
        ifc8.cpu_state = CPU_CHECK;
        cyc();
        cyc();
        check_eq("mid_chk_valid", ifc8.chk_valid, 1);
        #2;
        reset = 0;
        #1;
        check_eq("async_rst_valid", ifc8.chk_valid, 0);
        check_eq("async_rst_count", ifc8.ld_count, 0);
        ref_cnt = 0; ref_aerr = 0; ref_perr = 0;
        @(negedge clk);
        reset = 1;
        for (int i = 0; i < 3; i++) begin
            cyc();
            check_eq("post_rst_valid", ifc8.chk_valid, 0);
        end
        check_eq("post_rst_state", 32'(dut8.state), 32'(S_CHKDONE));
        ifc8.cpu_state = CPU_RUN;
        cyc();
        for (int i = 0; i < 4; i++) run_op(1, 0, 1, 0, 16'(i), 8'h00);
        clear_bus8();
        cyc();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
